// File: rtl/ofdm_bin_mapper.sv
// ofdm_bin_mapper
// Builds one frequency-domain OFDM symbol per frame for the IFFT. Payload bytes
// are split into 2-bit pairs (LSB pair first). Each pair selects one of four
// amplitude levels on a data bin. Fixed pilot tones and zero bins are inserted.
// Bins leave one per handshake through a registered valid/ready output stage.
// Sequencing is:
//   IDLE -> SYM   on the first byte of a packet,
//   SYM  -> PAD   once the s_last byte has been fully consumed,
//   PAD  -> IDLE  at the end of that symbol.

module ofdm_bin_mapper #(
  parameter int                   NFFT      = 128,
  parameter int                   W         = 16,
  parameter int                   FIRST_BIN = 4,
  parameter int                   N_DATA    = 52,
  parameter int                   PILOT0    = 56,
  parameter int                   PILOT1    = 57,
  parameter logic signed [W-1:0]  AMP_FULL  = 16'sd24576
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [7:0]   s_data,
  input  logic         s_valid,
  input  logic         s_last,
  output logic         s_ready,
  input  logic         pilot_en,
  output logic [W-1:0] m_real,
  output logic [W-1:0] m_imag,
  output logic [6:0]   m_bin,
  output logic         m_sof,
  output logic         m_eof,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         busy,
  output logic         underrun
);

  // Bin-class boundaries, widened by one bit so FIRST_BIN+N_DATA = NFFT still fits.
  localparam logic [7:0] DATA_LO  = 8'(FIRST_BIN);
  localparam logic [7:0] DATA_HI  = 8'(FIRST_BIN + N_DATA);
  localparam logic [6:0] P0_BIN   = 7'(PILOT0);
  localparam logic [6:0] P1_BIN   = 7'(PILOT1);
  localparam logic [6:0] LAST_BIN = 7'(NFFT - 1);
  localparam int         AMP_I    = int'(AMP_FULL);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYM  = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [6:0]          bin_cnt_reg, bin_cnt_next;
  logic [1:0]          pair_idx_reg, pair_idx_next;
  logic [7:0]          byte_reg, byte_next;
  logic                byte_vld_reg, byte_vld_next;
  logic                last_seen_reg, last_seen_next;
  logic                pilot_en_reg, pilot_en_next;
  logic signed [W-1:0] m_real_reg, m_real_next;
  logic [6:0]          m_bin_reg, m_bin_next;
  logic                m_sof_reg, m_sof_next;
  logic                m_eof_reg, m_eof_next;
  logic                m_valid_reg, m_valid_next;

  // Amplitude for each 2-bit pair value: 0, 1/3, 2/3 and full scale.
  // The fractions are truncated when the design is elaborated.
  logic signed [W-1:0] lvl_tbl [4];
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lvl
      localparam int LVL_I = (AMP_I * gi) / 3;
      assign lvl_tbl[gi] = W'(LVL_I);
    end
  endgenerate

  logic                advance;
  logic [6:0]          emit_bin;
  logic [7:0]          emit_bin_ext;
  logic                is_data;
  logic                is_pilot;
  logic                at_last;
  logic                consume;
  logic                pair_last;
  logic                blocked;
  logic                s_ready_int;
  logic                accept;
  logic                emit;
  logic [1:0]          cur_pair;
  logic signed [W-1:0] emit_val;

  // Classify the bin that would be emitted next.
  // Derive the byte-side handshake terms from that class.
  always_comb begin
    advance      = !m_valid_reg || m_ready;
    emit_bin     = (state_reg == IDLE) ? 7'd0 : bin_cnt_reg;
    emit_bin_ext = {1'b0, emit_bin};
    is_data      = (emit_bin_ext >= DATA_LO) && (emit_bin_ext < DATA_HI);
    is_pilot     = (emit_bin == P0_BIN) || (emit_bin == P1_BIN);
    at_last      = (emit_bin == LAST_BIN);
    pair_last    = (pair_idx_reg == 2'd3);
    consume      = (state_reg == SYM) && is_data && byte_vld_reg && advance;
    blocked      = (state_reg == SYM) && is_data && !byte_vld_reg;
    // The byte holding s_last is never replaced.
    // The next packet waits until PAD has drained back to IDLE.
    s_ready_int  = (state_reg != PAD) &&
                   (!byte_vld_reg || (consume && pair_last && !last_seen_reg));
    accept       = s_valid && s_ready_int;
  end

  // Pick the amplitude for the bin about to be emitted.
  always_comb begin
    emit_val = '0;
    cur_pair = '0;
    case (pair_idx_reg)
      2'd0:    cur_pair = byte_reg[1:0];
      2'd1:    cur_pair = byte_reg[3:2];
      2'd2:    cur_pair = byte_reg[5:4];
      default: cur_pair = byte_reg[7:6];
    endcase
    if (emit_bin == 7'd0) begin
      emit_val = '0;
    end else if (is_pilot) begin
      emit_val = pilot_en_reg ? AMP_FULL : '0;
    end else if (is_data && (state_reg == SYM) && byte_vld_reg) begin
      emit_val = lvl_tbl[cur_pair];
    end
  end

  // Next-state logic for the sequencer, the byte buffer and the output stage.
  always_comb begin
    state_next     = state_reg;
    bin_cnt_next   = bin_cnt_reg;
    pair_idx_next  = pair_idx_reg;
    byte_next      = byte_reg;
    byte_vld_next  = byte_vld_reg;
    last_seen_next = last_seen_reg;
    pilot_en_next  = pilot_en_reg;
    m_real_next    = m_real_reg;
    m_bin_next     = m_bin_reg;
    m_sof_next     = m_sof_reg;
    m_eof_next     = m_eof_reg;
    m_valid_next   = m_valid_reg;
    emit           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (advance) begin
          m_valid_next = 1'b0;
        end
        if (accept) begin
          state_next    = SYM;
          bin_cnt_next  = '0;
          pair_idx_next = '0;
          // Bin 0 needs no payload, so it can go out on the accept edge itself.
          emit          = advance;
        end
      end

      SYM, PAD: begin
        if (advance) begin
          if (blocked) begin
            // Starved data bin: leave a bubble and retry the same bin.
            m_valid_next = 1'b0;
          end else begin
            emit = 1'b1;
            if (consume) begin
              pair_idx_next = pair_idx_reg + 2'd1;
              if (pair_last) begin
                byte_vld_next = 1'b0;
                if (last_seen_reg) begin
                  state_next     = PAD;
                  last_seen_next = 1'b0;
                end
              end
            end
            // A packet ends at the end of a symbol.
            // This covers the case where the final pair lands on the last bin.
            if (at_last &&
                ((state_reg == PAD) || (consume && pair_last && last_seen_reg))) begin
              state_next = IDLE;
            end
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    if (emit) begin
      m_valid_next = 1'b1;
      m_bin_next   = emit_bin;
      m_sof_next   = (emit_bin == 7'd0);
      m_eof_next   = at_last;
      m_real_next  = emit_val;
      bin_cnt_next = at_last ? 7'd0 : emit_bin + 7'd1;
      if (emit_bin == 7'd0) begin
        pilot_en_next = pilot_en;
      end
    end

    if (accept) begin
      byte_next      = s_data;
      byte_vld_next  = 1'b1;
      last_seen_next = s_last;
    end
  end

  // State and output registers; reset discards any partial symbol.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      bin_cnt_reg   <= '0;
      pair_idx_reg  <= '0;
      byte_reg      <= '0;
      byte_vld_reg  <= 1'b0;
      last_seen_reg <= 1'b0;
      pilot_en_reg  <= 1'b0;
      m_real_reg    <= '0;
      m_bin_reg     <= '0;
      m_sof_reg     <= 1'b0;
      m_eof_reg     <= 1'b0;
      m_valid_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      bin_cnt_reg   <= bin_cnt_next;
      pair_idx_reg  <= pair_idx_next;
      byte_reg      <= byte_next;
      byte_vld_reg  <= byte_vld_next;
      last_seen_reg <= last_seen_next;
      pilot_en_reg  <= pilot_en_next;
      m_real_reg    <= m_real_next;
      m_bin_reg     <= m_bin_next;
      m_sof_reg     <= m_sof_next;
      m_eof_reg     <= m_eof_next;
      m_valid_reg   <= m_valid_next;
    end
  end

  assign s_ready  = rst_n && s_ready_int;
  assign m_real   = m_real_reg;
  assign m_imag   = '0;
  assign m_bin    = m_bin_reg;
  assign m_sof    = m_sof_reg;
  assign m_eof    = m_eof_reg;
  assign m_valid  = m_valid_reg;
  assign busy     = (state_reg != IDLE);
  assign underrun = blocked;

endmodule

// File: tb/tb_ofdm_bin_mapper.sv
// Directed testbench for ofdm_bin_mapper.
// Each packet's expected bin stream is rebuilt from its byte list.
// Data bins follow the 0/8192/16384/24576 level table, pilots sit at bins 56/57,
// and all other bins are zero.

module tb_ofdm_bin_mapper;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic        pilot_en;
  logic [15:0] m_real;
  logic [15:0] m_imag;
  logic [6:0]  m_bin;
  logic        m_sof;
  logic        m_eof;
  logic        m_valid;
  logic        m_ready;
  logic        busy;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] pkt [0:31];
  int         npkt;

  always #5 clk = ~clk;

  ofdm_bin_mapper dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_last   (s_last),
    .s_ready  (s_ready),
    .pilot_en (pilot_en),
    .m_real   (m_real),
    .m_imag   (m_imag),
    .m_bin    (m_bin),
    .m_sof    (m_sof),
    .m_eof    (m_eof),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .busy     (busy),
    .underrun (underrun)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lvl(input logic [1:0] p);
    case (p)
      2'd0:    return 16'd0;
      2'd1:    return 16'd8192;
      2'd2:    return 16'd16384;
      default: return 16'd24576;
    endcase
  endfunction

  // Expected amplitude of bin b in symbol s of the current packet.
  function automatic logic [15:0] exp_real(input int s, input int b);
    int         p;
    int         bi;
    logic [7:0] by;
    logic [7:0] sh;
    if (b == 56 || b == 57) return 16'd24576;
    if (b >= 4 && b <= 55) begin
      p  = s * 52 + (b - 4);
      bi = p / 4;
      if (bi < npkt) begin
        by = pkt[bi];
        sh = by >> (2 * (p % 4));
        return lvl(sh[1:0]);
      end
    end
    return 16'd0;
  endfunction

  function automatic logic [63:0] obs_pack();
    return {22'd0, m_valid, m_bin, m_sof, m_eof, m_real, m_imag};
  endfunction

  // Drives one packet and checks every transferred bin.
  // mode 1 adds a 5-cycle stall at bin 6 and random m_ready.
  // If gap_after >= 0, s_valid is withheld for gap_len cycles after that many bytes.
  // If rst_bin >= 0, an asynchronous reset is applied when that bin is shown.
  task automatic run(input string name, input int mode, input int gap_after,
                     input int gap_len, input int rst_bin);
    int          idx        = 0;
    int          cyc        = 0;
    int          nrx        = 0;
    int          total      = 128 * ((npkt + 12) / 13);
    int          last_sym   = total / 128 - 1;
    int          pad_thr    = 4 + ((npkt - 1) % 13) * 4 + 3;
    int          gap_cnt    = 0;
    int          stall_left = 0;
    bit          stall_done = 0;
    bit          prev_stall = 0;
    logic [63:0] saved      = '0;
    int          first_acc  = -1;
    int          first_val  = -1;
    int          urun       = 0;
    int          bubbles    = 0;
    int          s;
    int          b;
    while (nrx < total) begin
      @(negedge clk);
      if (mode == 1) begin
        if (!stall_done && m_valid && m_bin == 7'd6) begin
          stall_left = 5;
          stall_done = 1;
        end
        if (stall_left > 0) begin
          m_ready = 1'b0;
          stall_left--;
        end else begin
          m_ready = 1'($urandom_range(0, 1));
        end
      end else begin
        m_ready = 1'b1;
      end
      s_valid = (idx < npkt) && (gap_cnt == 0);
      s_data  = s_valid ? pkt[idx] : 8'h00;
      s_last  = s_valid && (idx == npkt - 1);
      #1;
      if (prev_stall) chk({name, " stall_hold"}, obs_pack(), saved);
      prev_stall = m_valid && !m_ready;
      saved      = obs_pack();
      if (first_val < 0 && m_valid) first_val = cyc;
      if (m_valid && (nrx / 128) == last_sym && m_bin > 7'(pad_thr) && m_bin < 7'd127)
        chk({name, " s_ready_pad"}, {63'd0, s_ready}, 64'd0);
      if (m_valid && m_ready) begin
        s = nrx / 128;
        b = nrx % 128;
        chk({name, " bin"}, obs_pack(),
            {22'd0, 1'b1, 7'(b), (b == 0), (b == 127), exp_real(s, b), 16'h0000});
        nrx++;
      end else if (nrx > 0 && !m_valid) begin
        bubbles++;
      end
      if (underrun && !m_valid) urun++;
      if (s_valid && s_ready) begin
        if (first_acc < 0) first_acc = cyc;
        idx++;
        if (idx == gap_after) gap_cnt = gap_len;
      end else if (gap_cnt > 0) begin
        gap_cnt--;
      end
      if (rst_bin >= 0 && m_valid && m_bin == 7'(rst_bin)) begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        rst_n   = 1'b0;
        #1;
        chk({name, " rst_m_valid"}, {63'd0, m_valid}, 64'd0);
        chk({name, " rst_s_ready"}, {63'd0, s_ready}, 64'd0);
        chk({name, " rst_busy"}, {63'd0, busy}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({name, " post_rst_s_ready"}, {63'd0, s_ready}, 64'd1);
        chk({name, " post_rst_busy"}, {63'd0, busy}, 64'd0);
        $display("%s: reset applied at bin %0d after %0d bins", name, rst_bin, nrx);
        return;
      end
      cyc++;
      if (cyc > 4000) begin
        chk({name, " timeout_bins"}, 64'(nrx), 64'(total));
        break;
      end
    end
    chk({name, " latency"}, 64'(first_val - first_acc), 64'd1);
    if (gap_after >= 0) begin
      chk({name, " bubbles_seen"}, {63'd0, bubbles > 0}, 64'd1);
      chk({name, " underrun_seen"}, {63'd0, urun > 0}, 64'd1);
    end else begin
      chk({name, " bubbles"}, 64'(bubbles), 64'd0);
      chk({name, " underrun"}, 64'(urun), 64'd0);
    end
    @(negedge clk);
    m_ready = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    #1;
    chk({name, " end_m_valid"}, {63'd0, m_valid}, 64'd0);
    chk({name, " end_busy"}, {63'd0, busy}, 64'd0);
    chk({name, " end_s_ready"}, {63'd0, s_ready}, 64'd1);
    $display("%s: %0d bytes, %0d bins, %0d bubbles, %0d underrun cycles", name, npkt, nrx,
             bubbles, urun);
  endtask

  initial begin
    rst_n    = 1'b0;
    s_data   = 8'h00;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    pilot_en = 1'b1;
    m_ready  = 1'b1;
    npkt     = 0;

    // T1: reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset m_valid", {63'd0, m_valid}, 64'd0);
    chk("reset s_ready", {63'd0, s_ready}, 64'd0);
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset underrun", {63'd0, underrun}, 64'd0);
    chk("reset m_real", 64'(m_real), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release s_ready", {63'd0, s_ready}, 64'd1);
    chk("release busy", {63'd0, busy}, 64'd0);
    $display("T1: reset checked");

    // T2: one full symbol of 0xE4
    npkt = 13;
    for (int i = 0; i < 13; i++) pkt[i] = 8'hE4;
    run("T2", 0, -1, 0, -1);

    // T3: short packet, PAD for the remainder of the symbol
    npkt   = 2;
    pkt[0] = 8'hFF;
    pkt[1] = 8'hFF;
    run("T3", 0, -1, 0, -1);

    // T4: two back-to-back symbols
    npkt = 26;
    for (int i = 0; i < 26; i++) pkt[i] = 8'((i * 37 + 11) & 8'hFF);
    run("T4", 0, -1, 0, -1);

    // T5: T2 stimulus under backpressure
    npkt = 13;
    for (int i = 0; i < 13; i++) pkt[i] = 8'hE4;
    run("T5", 1, -1, 0, -1);

    // T6: byte gap causing underrun at bin 16
    npkt = 13;
    for (int i = 0; i < 13; i++) pkt[i] = 8'((i * 29 + 3) & 8'hFF);
    run("T6gap", 0, 3, 10, -1);

    // T6: async reset at bin 40, then a clean packet restarting at bin 0
    run("T6rst", 0, -1, 0, 40);
    for (int i = 0; i < 13; i++) pkt[i] = 8'hE4;
    run("T6after", 0, -1, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
